// File: rtl/ram_dp_init_pkg.sv
// ram_dp_init_pkg: shared FSM encodings and lane-mask helper for the fetch-side RAMs.
// Contents: RAM_ST_INIT/RAM_ST_READY state constants, expand_mask() lane-to-bit mask expansion.
package ram_dp_init_pkg;
    localparam logic RAM_ST_INIT  = 1'b0;
    localparam logic RAM_ST_READY = 1'b1;
    localparam int   MAX_WIDTH    = 1024;
    localparam int   MAX_LANES    = 128;

    // Widths are capped at MAX_*; callers size the result down with a cast.
    function automatic logic [MAX_WIDTH-1:0] expand_mask(input logic [MAX_LANES-1:0] lanes,
                                                         input int lane_width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_WIDTH; b++)
            m[b] = (b / lane_width < MAX_LANES) && lanes[7'(b / lane_width)];
        return m;
    endfunction
endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: INIT/READY sequencer that sweeps every RAM entry once after reset.
// Ports: clk, reset (sync, active-high); init_we/init_index drive the sweep write;
//        init_busy is high while the sweep runs.
module ram_init_seq
    import ram_dp_init_pkg::*;
#(
    parameter int INDEXSIZE = 256,
    parameter int LOGINDEX  = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_we,
    output logic [LOGINDEX-1:0] init_index,
    output logic                init_busy
);
    localparam logic [LOGINDEX:0] LAST = (LOGINDEX + 1)'(INDEXSIZE - 1);

    logic              state;
    logic [LOGINDEX:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RAM_ST_INIT;
            count <= '0;
        end else if (state == RAM_ST_INIT) begin
            count <= count + 1'b1;
            if (count == LAST)
                state <= RAM_ST_READY;
        end
    end

    assign init_busy  = state == RAM_ST_INIT;
    assign init_we    = init_busy && (count <= LAST);
    assign init_index = count[LOGINDEX-1:0];
endmodule

// File: rtl/ram_dp_init.sv
// ram_dp_init: 1R/1W RAM with per-lane write masks, cleared by a post-reset init sweep.
// Ports: clk, reset (sync, active-high); read port rd_en_in/rd_index_in -> rd_data_out/rd_valid_out
//        (1-cycle latency); write port we_in/wr_mask_in/wr_index_in/wr_data_in; init_busy_out.
// Option: define RAM_WR_BYPASS_EN for write-first same-index collisions (read-first otherwise).
module ram_dp_init
    import ram_dp_init_pkg::*;
#(
    parameter int                   DATAWIDTH = 64,
    parameter int                   INDEXSIZE = 256,
    parameter int                   LOGINDEX  = 8,
    parameter logic [DATAWIDTH-1:0] INITVALUE = '0,
    parameter int                   NLANES    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en_in,
    input  logic [LOGINDEX-1:0]  rd_index_in,
    output logic [DATAWIDTH-1:0] rd_data_out,
    output logic                 rd_valid_out,
    input  logic                 we_in,
    input  logic [NLANES-1:0]    wr_mask_in,
    input  logic [LOGINDEX-1:0]  wr_index_in,
    input  logic [DATAWIDTH-1:0] wr_data_in,
    output logic                 init_busy_out
);
    localparam int                LW   = DATAWIDTH / NLANES;
    localparam logic [LOGINDEX:0] LAST = (LOGINDEX + 1)'(INDEXSIZE - 1);

    logic [DATAWIDTH-1:0] ram [INDEXSIZE];
    logic                 init_we, init_busy;
    logic [LOGINDEX-1:0]  init_index;
    logic                 rd_hit, wr_hit, user_we, user_re, mem_we;
    logic [LOGINDEX-1:0]  mem_index;
    logic [DATAWIDTH-1:0] wr_bmask, mem_mask, mem_data, rd_word;

    ram_init_seq #(
        .INDEXSIZE (INDEXSIZE),
        .LOGINDEX  (LOGINDEX)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .init_we    (init_we),
        .init_index (init_index),
        .init_busy  (init_busy)
    );

    assign rd_hit   = {1'b0, rd_index_in} <= LAST;
    assign wr_hit   = {1'b0, wr_index_in} <= LAST;
    assign wr_bmask = DATAWIDTH'(expand_mask(MAX_LANES'(wr_mask_in), LW));
    assign user_we  = !init_busy && we_in && wr_hit;
    assign user_re  = !init_busy && rd_en_in;

    // The sweep owns the single write port while busy; user writes are refused then.
    assign mem_we    = init_we || user_we;
    assign mem_index = init_we ? init_index : wr_index_in;
    assign mem_mask  = init_we ? '1 : wr_bmask;
    assign mem_data  = init_we ? INITVALUE : wr_data_in;

    always_ff @(posedge clk) begin
        if (mem_we)
            ram[mem_index] <= (ram[mem_index] & ~mem_mask) | (mem_data & mem_mask);
    end

    always_comb begin
        rd_word = rd_hit ? ram[rd_index_in] : '0;
`ifdef RAM_WR_BYPASS_EN
        if (user_we && wr_index_in == rd_index_in)
            rd_word = (rd_word & ~wr_bmask) | (wr_data_in & wr_bmask);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_out <= 1'b0;
            rd_data_out  <= '0;
        end else begin
            rd_valid_out <= user_re;
            if (user_re)
                rd_data_out <= rd_word;
        end
    end

    assign init_busy_out = init_busy;
endmodule

// File: tb/tb_ram_dp_init.sv
// tb_ram_dp_init: table-driven and randomized checks of ram_dp_init against a lane-level model.
module tb_ram_dp_init;
    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en, we, rd_valid, busy;
    logic [7:0]  rd_index, wr_index, mask;
    logic [63:0] rd_data, wr_data;

    logic        s_rd_en, s_we, s_rd_valid, s_busy;
    logic [3:0]  s_rd_index, s_wr_index;
    logic [1:0]  s_mask;
    logic [15:0] s_rd_data, s_wr_data;

    int errors = 0;
    int checks = 0;

    logic [63:0] mdl [256];
    logic        m_valid;
    logic [63:0] m_data;

    always #5 clk = ~clk;

    ram_dp_init #(
        .DATAWIDTH (64), .INDEXSIZE (256), .LOGINDEX (8), .INITVALUE (64'hA5), .NLANES (8)
    ) dut (
        .clk (clk), .reset (reset),
        .rd_en_in (rd_en), .rd_index_in (rd_index), .rd_data_out (rd_data), .rd_valid_out (rd_valid),
        .we_in (we), .wr_mask_in (mask), .wr_index_in (wr_index), .wr_data_in (wr_data),
        .init_busy_out (busy)
    );

    ram_dp_init #(
        .DATAWIDTH (16), .INDEXSIZE (12), .LOGINDEX (4), .INITVALUE (16'h3C), .NLANES (2)
    ) dut_s (
        .clk (clk), .reset (reset),
        .rd_en_in (s_rd_en), .rd_index_in (s_rd_index), .rd_data_out (s_rd_data), .rd_valid_out (s_rd_valid),
        .we_in (s_we), .wr_mask_in (s_mask), .wr_index_in (s_wr_index), .wr_data_in (s_wr_data),
        .init_busy_out (s_busy)
    );

    typedef struct {
        logic        we;
        logic [7:0]  mask;
        logic [7:0]  widx;
        logic [63:0] wdata;
        logic        rd;
        logic [7:0]  ridx;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

`ifdef RAM_WR_BYPASS_EN
    localparam logic [63:0] COLL = 64'hFFFF;
`else
    localparam logic [63:0] COLL = 64'hA5;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int l = 0; l < 8; l++)
            if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
        return r;
    endfunction

    task automatic model(input logic w, input logic [7:0] m, input logic [7:0] wi, input logic [63:0] wd,
                         input logic r, input logic [7:0] ri);
        m_valid = r;
        if (r) begin
            m_data = mdl[ri];
`ifdef RAM_WR_BYPASS_EN
            if (w && wi == ri) m_data = merge(mdl[ri], wd, m);
`endif
        end
        if (w) mdl[wi] = merge(mdl[wi], wd, m);
    endtask

    task automatic drive(input logic w, input logic [7:0] m, input logic [7:0] wi, input logic [63:0] wd,
                         input logic r, input logic [7:0] ri);
        we = w; mask = m; wr_index = wi; wr_data = wd; rd_en = r; rd_index = ri;
        model(w, m, wi, wd, r, ri);
        cyc();
        we = 1'b0; rd_en = 1'b0;
    endtask

    task automatic fill_model();
        for (int i = 0; i < 256; i++) mdl[i] = 64'hA5;
    endtask

    task automatic s_op(input logic w, input logic [1:0] m, input logic [3:0] wi, input logic [15:0] wd,
                        input logic r, input logic [3:0] ri);
        s_we = w; s_mask = m; s_wr_index = wi; s_wr_data = wd; s_rd_en = r; s_rd_index = ri;
        cyc();
        s_we = 1'b0; s_rd_en = 1'b0;
    endtask

    initial begin
        vec_t vt [10];
        int   busy_cycles;
        bit   saw_valid;
        bit   w, r;
        logic [7:0] m, wi, ri;
        logic [63:0] wd;

        vt[0] = '{1'b1, 8'h0F, 8'd7,  64'h1122334455667788, 1'b0, 8'd0,  1'b0, 64'hA5};
        vt[1] = '{1'b0, 8'h00, 8'd0,  64'h0,                1'b1, 8'd7,  1'b1, 64'h0000000055667788};
        vt[2] = '{1'b1, 8'hFF, 8'd3,  64'hFFFF,             1'b1, 8'd3,  1'b1, COLL};
        vt[3] = '{1'b0, 8'h00, 8'd0,  64'h0,                1'b1, 8'd3,  1'b1, 64'hFFFF};
        vt[4] = '{1'b1, 8'hFF, 8'd9,  64'h42,               1'b0, 8'd0,  1'b0, 64'hFFFF};
        vt[5] = '{1'b0, 8'h00, 8'd0,  64'h0,                1'b1, 8'd9,  1'b1, 64'h42};
        vt[6] = '{1'b0, 8'h00, 8'd0,  64'h0,                1'b0, 8'd0,  1'b0, 64'h42};
        vt[7] = '{1'b1, 8'h00, 8'd9,  64'hDEADBEEF,         1'b1, 8'd9,  1'b1, 64'h42};
        vt[8] = '{1'b1, 8'hFF, 8'd10, 64'h77,               1'b1, 8'd7,  1'b1, 64'h0000000055667788};
        vt[9] = '{1'b0, 8'h00, 8'd0,  64'h0,                1'b1, 8'd10, 1'b1, 64'h77};

        reset = 1'b1; rd_en = 1'b0; we = 1'b0; mask = '0; rd_index = '0; wr_index = '0; wr_data = '0;
        s_rd_en = 1'b0; s_we = 1'b0; s_mask = '0; s_rd_index = '0; s_wr_index = '0; s_wr_data = '0;
        repeat (3) cyc();
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_valid", 64'(rd_valid), 64'd0);
        chk("reset_data", rd_data, 64'd0);

        // Sweep with refused requests at sweep cycle 2.
        reset = 1'b0;
        busy_cycles = 0; saw_valid = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            busy_cycles++;
            if (i == 2) begin
                we = 1'b1; mask = 8'hFF; wr_index = 8'd5; wr_data = 64'hFFFF_FFFF; rd_en = 1'b1; rd_index = 8'd5;
            end
            if (i == 3) begin
                we = 1'b0; rd_en = 1'b0;
            end
            cyc();
            if (rd_valid) saw_valid = 1;
        end
        we = 1'b0; rd_en = 1'b0;
        chk("sweep_len", 64'(busy_cycles), 64'd256);
        chk("init_no_valid", 64'(saw_valid), 64'd0);
        chk("busy_low", 64'(busy), 64'd0);
        fill_model();

        foreach (vt[i]) ;
        drive(0, 0, 0, 0, 1, 8'd0);   chk("init_rd0", rd_data, 64'hA5);
        drive(0, 0, 0, 0, 1, 8'd128); chk("init_rd128", rd_data, 64'hA5);
        drive(0, 0, 0, 0, 1, 8'd255); chk("init_rd255", rd_data, 64'hA5);
        drive(0, 0, 0, 0, 1, 8'd5);   chk("init_rd5", rd_data, 64'hA5);
        chk("rd_valid", 64'(rd_valid), 64'd1);

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].we, vt[i].mask, vt[i].widx, vt[i].wdata, vt[i].rd, vt[i].ridx);
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(vt[i].exp_valid));
            chk($sformatf("vec%0d_data", i), rd_data, vt[i].exp_data);
        end

        // Narrow instance: out-of-range accesses and lane masks on 8-bit lanes.
        chk("s_busy", 64'(s_busy), 64'd0);
        s_op(1, 2'b11, 4'd13, 16'h1234, 1, 4'd13);
        chk("s_oor_valid", 64'(s_rd_valid), 64'd1);
        chk("s_oor_data", 64'(s_rd_data), 64'd0);
        s_op(0, 2'b00, 4'd0, 16'h0, 1, 4'd11);
        chk("s_last_init", 64'(s_rd_data), 64'h3C);
        s_op(1, 2'b10, 4'd11, 16'hABCD, 0, 4'd0);
        s_op(0, 2'b00, 4'd0, 16'h0, 1, 4'd11);
        chk("s_lane_hi", 64'(s_rd_data), 64'hAB3C);
        s_op(0, 2'b00, 4'd0, 16'h0, 1, 4'd12);
        chk("s_oor12", 64'(s_rd_data), 64'd0);

        // Model holds the post-table contents; random traffic over a few indices forces collisions.
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom); r = 1'($urandom);
            m = 8'($urandom); wi = 8'($urandom_range(0, 15)); ri = 8'($urandom_range(0, 15));
            wd = {$urandom, $urandom};
            drive(w, m, wi, wd, r, ri);
            chk("rand_valid", 64'(rd_valid), 64'(m_valid));
            if (m_valid) chk("rand_data", rd_data, m_data);
        end

        // Reset while READY, then a one-cycle reset at sweep cycle 100.
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_ready_valid", 64'(rd_valid), 64'd0);
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cycles++;
            cyc();
        end
        chk("pre_mid_busy", 64'(busy_cycles), 64'd100);
        reset = 1'b1; cyc(); reset = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            busy_cycles++;
            cyc();
        end
        chk("mid_sweep_len", 64'(busy_cycles), 64'd256);
        fill_model();
        drive(0, 0, 0, 0, 1, 8'd9);  chk("resweep_rd9", rd_data, 64'hA5);
        drive(0, 0, 0, 0, 1, 8'd7);  chk("resweep_rd7", rd_data, 64'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
